// File: rtl/systolic_writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_pkg
//  Purpose  : Shared widths, tile/beat types, FSM encoding and helpers for
//             the systolic-array result writeback block.
//  Revision : 1.0 - initial release
// ============================================================================
package writeback_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int DIM_WIDTH  = 16;
    localparam int BANDWIDTH  = 4;

    localparam int TILE_DIM   = 8;
    localparam int HALF       = BANDWIDTH;

    typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][DATA_WIDTH-1:0] tile_t;
    typedef logic [BANDWIDTH-1:0][DATA_WIDTH-1:0]              beat_data_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } wb_state_t;

    // Out-of-range row/column counts mean "whole tile".
    function automatic logic [3:0] clamp_dim(input logic [3:0] v);
        return (v == 4'd0 || v > 4'd8) ? 4'd8 : v;
    endfunction
endpackage
`default_nettype wire

// File: rtl/systolic_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_writeback_if
//  Purpose  : Memory write bus with waitrequest backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
interface systolic_writeback_if;
    import writeback_pkg::*;

    logic                  write;
    logic [ADDR_WIDTH-1:0] write_addr;
    beat_data_t            writedata;
    logic [BANDWIDTH-1:0]  word_en;
    logic                  waitrequest;

    modport master (output write, write_addr, writedata, word_en,
                    input  waitrequest);
    modport slave  (input  write, write_addr, writedata, word_en,
                    output waitrequest);
endinterface
`default_nettype wire

// File: rtl/systolic_writeback_units.sv
`default_nettype none
// ============================================================================
//  Module   : Counter / Accum
//  Purpose  : Reusable up-counter and load/accumulate register used for the
//             writeback row index and row base address.
//  Revision : 1.0 - initial release
// ============================================================================
module Counter #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    output logic [WIDTH-1:0]      q_o
);
    // Clear has priority over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    q_o <= '0;
        else if (clr_i) q_o <= '0;
        else if (en_i)  q_o <= q_o + WIDTH'(1);
    end
endmodule

module Accum #(
    parameter int WIDTH     = 16,
    parameter int OFF_WIDTH = 16
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_ni,
    input  wire logic                 load_i,
    input  wire logic                 en_i,
    input  wire logic [WIDTH-1:0]     d_i,
    input  wire logic [OFF_WIDTH-1:0] offset_i,
    output logic [WIDTH-1:0]          q_o
);
    // Load a base value, then add the offset on each enable (modulo 2^WIDTH).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     q_o <= '0;
        else if (load_i) q_o <= d_i;
        else if (en_i)   q_o <= q_o + WIDTH'(offset_i);
    end
endmodule
`default_nettype wire

// File: rtl/systolic_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_writeback
//  Purpose  : Captures one 8x8 result tile and writes it row-major as
//             half-row beats, masking rows/columns of partial edge tiles.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_writeback
    import writeback_pkg::*;
(
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire tile_t                 tile,
    input  wire logic [ADDR_WIDTH-1:0] base_C,
    input  wire logic [DIM_WIDTH-1:0]  dim_col_C,
    input  wire logic [3:0]            valid_rows,
    input  wire logic [3:0]            valid_cols,
    systolic_writeback_if.master       mem,
    output logic                       busy,
    output logic                       done
);
    wb_state_t             state_q;
    tile_t                 tile_q;
    logic [DIM_WIDTH-1:0]  dim_col_q;
    logic [3:0]            rows_q;
    logic [3:0]            cols_q;
    logic [2:0]            row_q;
    logic [ADDR_WIDTH-1:0] row_addr_q;

    logic start_acc;
    logic beat_acc;
    logic wide;
    logic last_row;
    logic row_adv;

    assign start_acc = start && (state_q == ST_IDLE);
    assign beat_acc  = mem.write && !mem.waitrequest;
    assign wide      = (cols_q > 4'(HALF));
    assign last_row  = ({1'b0, row_q} == (rows_q - 4'd1));
    assign row_adv   = beat_acc && ((state_q == ST_HI) || (state_q == ST_LO && !wide));

    // Snapshot the tile and configuration so the driver may move on at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tile_q    <= '0;
            dim_col_q <= '0;
            rows_q    <= 4'd8;
            cols_q    <= 4'd8;
        end else if (start_acc) begin
            tile_q    <= tile;
            dim_col_q <= dim_col_C;
            rows_q    <= clamp_dim(valid_rows);
            cols_q    <= clamp_dim(valid_cols);
        end
    end

    // Sequence LO/HI half-row beats across rows, then pulse DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_acc) state_q <= ST_LO;
                ST_LO: begin
                    if (beat_acc) begin
                        if (wide)          state_q <= ST_HI;
                        else if (last_row) state_q <= ST_DONE;
                        else               state_q <= ST_LO;
                    end
                end
                ST_HI: begin
                    if (beat_acc) state_q <= last_row ? ST_DONE : ST_LO;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    Counter #(.WIDTH(3)) u_row_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .clr_i  (start_acc),
        .en_i   (row_adv && !last_row),
        .q_o    (row_q)
    );

    Accum #(.WIDTH(ADDR_WIDTH), .OFF_WIDTH(DIM_WIDTH)) u_row_addr (
        .clk_i    (clock),
        .rst_ni   (reset),
        .load_i   (start_acc),
        .en_i     (row_adv && !last_row),
        .d_i      (base_C),
        .offset_i (dim_col_q),
        .q_o      (row_addr_q)
    );

    // Bus outputs are a pure decode of registered state, so they hold
    // steady under waitrequest and zero out whenever no beat is presented.
    always_comb begin
        logic       hi;
        logic [2:0] col;
        mem.write      = 1'b0;
        mem.write_addr = '0;
        mem.writedata  = '0;
        mem.word_en    = '0;
        hi             = (state_q == ST_HI);
        col            = 3'd0;
        if (state_q == ST_LO || state_q == ST_HI) begin
            mem.write      = 1'b1;
            mem.write_addr = row_addr_q + (hi ? ADDR_WIDTH'(HALF) : '0);
            for (int m = 0; m < BANDWIDTH; m++) begin
                col              = 3'(m) + (hi ? 3'(HALF) : 3'd0);
                mem.writedata[m] = tile_q[row_q][col];
                mem.word_en[m]   = ({1'b0, col} < cols_q);
            end
        end
    end

    // Status flags derived from the state register.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_writeback
//  Purpose  : Self-checking bench for systolic_writeback with a tile-level
//             reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_writeback;
    import writeback_pkg::*;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        beat_data_t            data;
        logic [BANDWIDTH-1:0]  en;
    } beat_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    tile_t                 tile  = '0;
    logic [ADDR_WIDTH-1:0] base_C = '0;
    logic [DIM_WIDTH-1:0]  dim_col_C = '0;
    logic [3:0]            valid_rows = 4'd8;
    logic [3:0]            valid_cols = 4'd8;
    logic                  busy;
    logic                  done;

    systolic_writeback_if bus();

    systolic_writeback dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .tile       (tile),
        .base_C     (base_C),
        .dim_col_C  (dim_col_C),
        .valid_rows (valid_rows),
        .valid_cols (valid_cols),
        .mem        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int    n_checks = 0;
    int    n_fail   = 0;
    logic  chk_en   = 1'b0;
    beat_t exp_q[$];
    logic [ADDR_WIDTH-1:0] obs_addr[$];
    logic [BANDWIDTH-1:0]  obs_en[$];
    logic [DATA_WIDTH-1:0] obs_d0[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic tile_t mk_tile(input int seed);
        tile_t t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                t[r][c] = 16'(seed + 16 * r + c);
        return t;
    endfunction

    // Reference: list every beat the tile must produce, in order.
    task automatic build_model(input tile_t tl, input logic [ADDR_WIDTH-1:0] base,
                               input logic [DIM_WIDTH-1:0] stride,
                               input logic [3:0] vr, input logic [3:0] vc);
        int rows, cols, halves;
        beat_t b;
        rows   = (vr == 0 || vr > 8) ? 8 : int'(vr);
        cols   = (vc == 0 || vc > 8) ? 8 : int'(vc);
        halves = (cols > 4) ? 2 : 1;
        exp_q.delete();
        for (int r = 0; r < rows; r++)
            for (int h = 0; h < halves; h++) begin
                b.addr = ADDR_WIDTH'(int'(base) + r * int'(stride) + 4 * h);
                for (int m = 0; m < 4; m++) begin
                    b.data[m] = tl[r][4*h+m];
                    b.en[m]   = (4 * h + m < cols);
                end
                exp_q.push_back(b);
            end
    endtask

    // Bus monitor: beat contents, stall stability, idle zeroing.
    logic                  prev_stall = 1'b0;
    logic [ADDR_WIDTH-1:0] prev_addr;
    beat_data_t            prev_data;
    logic [BANDWIDTH-1:0]  prev_en;
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                if (bus.write) begin
                    if (prev_stall)
                        chk("stall_hold", {bus.write_addr, bus.writedata, bus.word_en},
                            {prev_addr, prev_data, prev_en});
                    if (!bus.waitrequest) begin
                        chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("beat_addr", bus.write_addr, e.addr);
                            chk("beat_data", bus.writedata, e.data);
                            chk("beat_en", bus.word_en, e.en);
                        end
                        obs_addr.push_back(bus.write_addr);
                        obs_en.push_back(bus.word_en);
                        obs_d0.push_back(bus.writedata[0]);
                    end
                    prev_stall = bus.waitrequest;
                    prev_addr  = bus.write_addr;
                    prev_data  = bus.writedata;
                    prev_en    = bus.word_en;
                end else begin
                    chk("idle_zero", {bus.writedata, bus.word_en}, '0);
                    prev_stall = 1'b0;
                end
            end
        end
    end

    // One transfer: optional stall window, second start, reset pulse.
    task automatic run_case(input string nm, input tile_t tl, input tile_t tl2,
                            input logic [ADDR_WIDTH-1:0] base, input logic [DIM_WIDTH-1:0] stride,
                            input logic [3:0] vr, input logic [3:0] vc,
                            input int stall_s, input int stall_n,
                            input int restart_cyc, input int rst_cyc,
                            output int done_cyc);
        int  exp_done;
        bit  aborted;
        obs_addr.delete(); obs_en.delete(); obs_d0.delete();
        build_model(tl, base, stride, vr, vc);
        exp_done = exp_q.size() + stall_n + 1;
        done_cyc = -1;
        aborted  = 0;
        @(posedge clock); #1;
        tile = tl; base_C = base; dim_col_C = stride;
        valid_rows = vr; valid_cols = vc; start = 1'b1;
        @(posedge clock); #1;
        for (int t = 1; t <= 60; t++) begin
            bus.waitrequest = (t >= stall_s && t < stall_s + stall_n);
            start = (t == restart_cyc);
            if (start) tile = tl2;
            if (t == rst_cyc) begin
                #1 reset = 1'b0;
                #1;
                chk({nm, "_rst_write"}, bus.write, 1'b0);
                chk({nm, "_rst_bus"}, {bus.write_addr, bus.writedata, bus.word_en}, '0);
                chk({nm, "_rst_flags"}, {busy, done}, 2'b00);
                @(posedge clock); #2 reset = 1'b1;
                exp_q.delete();
                aborted = 1;
                break;
            end
            @(negedge clock);
            if (t == 1) chk({nm, "_busy_on"}, busy, 1'b1);
            if (done && done_cyc < 0) done_cyc = t;
            if (done_cyc > 0 && t == done_cyc + 1) chk({nm, "_done_pulse"}, {busy, done}, 2'b00);
            @(posedge clock); #1;
            if (done_cyc > 0 && t >= done_cyc + 3) break;
        end
        bus.waitrequest = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            chk({nm, "_done_cycle"}, done_cyc, exp_done);
            chk({nm, "_all_beats"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        int dc;
        tile_t t0, t1;
        bus.waitrequest = 1'b0;
        t0 = mk_tile(0);
        t1 = mk_tile(16'h5000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_bus", {bus.write, bus.write_addr, bus.writedata, bus.word_en}, '0);
        chk("reset_flags", {busy, done}, 2'b00);
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Full tile.
        run_case("full", t0, t0, 16'h100, 16'd8, 4'd8, 4'd8, 0, 0, 0, 0, dc);
        chk("full_done17", dc, 17);
        chk("full_nbeats", obs_addr.size(), 16);
        chk("full_addr0", obs_addr[0], 16'h100);
        chk("full_addr1", obs_addr[1], 16'h104);
        chk("full_addr15", obs_addr[15], 16'h13C);
        chk("full_en", obs_en[9], 4'hF);

        // Edge tile; start during DONE must be ignored.
        run_case("edge", t0, t1, 16'h0, 16'd20, 4'd3, 4'd6, 0, 0, 7, 0, dc);
        chk("edge_done7", dc, 7);
        chk("edge_addrs", {obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3], obs_addr[4], obs_addr[5]},
            {16'd0, 16'd4, 16'd20, 16'd24, 16'd40, 16'd44});
        chk("edge_en", {obs_en[0], obs_en[1], obs_en[4], obs_en[5]}, 16'hF3F3);

        // Narrow tile, rows=0 clamps to 8.
        run_case("narrow", t0, t0, 16'h200, 16'd8, 4'd0, 4'd2, 0, 0, 0, 0, dc);
        chk("narrow_nbeats", obs_addr.size(), 8);
        chk("narrow_en", obs_en[7], 4'h3);
        chk("narrow_addr7", obs_addr[7], 16'h238);

        // Backpressure on beat 5.
        run_case("stall", t0, t0, 16'h100, 16'd8, 4'd8, 4'd8, 5, 3, 0, 0, dc);
        chk("stall_done20", dc, 20);
        chk("stall_nbeats", obs_addr.size(), 16);

        // Second start while busy.
        run_case("busy_start", t0, t1, 16'h100, 16'd8, 4'd8, 4'd8, 0, 0, 4, 0, dc);
        chk("busy_start_d8", obs_d0[8], 16'h0040);

        // Address wrap-around.
        run_case("wrap", t0, t0, 16'hFFF0, 16'h0010, 4'd2, 4'd8, 0, 0, 0, 0, dc);
        chk("wrap_addr2", obs_addr[2], 16'h0000);
        chk("wrap_addr3", obs_addr[3], 16'h0004);

        // Reset during beat 7, then a clean transfer from row 0.
        run_case("midrst", t0, t0, 16'h100, 16'd8, 4'd8, 4'd8, 0, 0, 0, 7, dc);
        chk("midrst_nbeats", obs_addr.size(), 6);
        run_case("after_rst", mk_tile(16'h300), t0, 16'h40, 16'd8, 4'd8, 4'd8, 0, 0, 0, 0, dc);
        chk("after_rst_done17", dc, 17);
        chk("after_rst_addr0", obs_addr[0], 16'h40);
        chk("after_rst_d0", obs_d0[0], 16'h0300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
